// File: rtl/nrs_seq_gen.sv
// NB-IoT NRS QPSK sign-bit generator: 36.211 Gold sequence c(n),
// one pair per cycle for one OFDM symbol per request.
module nrs_seq_gen #(
   parameter int N_C      = 1600,
   parameter int M_OFFSET = 218,
   parameter int N_PAIRS  = 2,
   parameter int CNT_W    = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [30:0] c_init,
   input  logic [1:0]  addr_base,
   output logic        busy,
   output logic        nrs_valid,
   output logic        nrs_r,
   output logic        nrs_i,
   output logic [1:0]  wr_addr,
   output logic        done
);

   localparam int SKIP_N = N_C + M_OFFSET;

   typedef enum logic [1:0] {IDLE, SKIP, EMIT, DONE} state_t;

   state_t           state;
   logic [30:0]      x1;
   logic [30:0]      x2;
   logic [CNT_W-1:0] skip_cnt;
   logic [1:0]       pair_cnt;
   logic [1:0]       base;
   logic             busy_q;
   logic             valid_q;
   logic             done_q;

   function automatic logic [30:0] x1_shift(input logic [30:0] x);
      return {x[3] ^ x[0], x[30:1]};
   endfunction

   function automatic logic [30:0] x2_shift(input logic [30:0] x);
      return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         x1       <= '0;
         x2       <= '0;
         skip_cnt <= '0;
         pair_cnt <= '0;
         base     <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  x1       <= 31'h1;
                  x2       <= c_init;
                  base     <= addr_base;
                  skip_cnt <= '0;
                  pair_cnt <= '0;
                  busy_q   <= 1'b1;
                  valid_q  <= (SKIP_N == 0);
                  state    <= (SKIP_N == 0) ? EMIT : SKIP;
               end
            end
            SKIP: begin
               x1       <= x1_shift(x1);
               x2       <= x2_shift(x2);
               skip_cnt <= skip_cnt + 1'b1;
               if (32'(skip_cnt) == SKIP_N - 1) begin
                  valid_q <= 1'b1;
                  state   <= EMIT;
               end
            end
            EMIT: begin
               // two shifts per pair: c(2k), c(2k+1) consumed together
               x1       <= x1_shift(x1_shift(x1));
               x2       <= x2_shift(x2_shift(x2));
               pair_cnt <= pair_cnt + 1'b1;
               if (32'(pair_cnt) == N_PAIRS - 1) begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy      = busy_q;
      nrs_valid = valid_q;
      done      = done_q;
      nrs_r     = valid_q & (x1[0] ^ x2[0]);
      nrs_i     = valid_q & (x1[1] ^ x2[1]);
      wr_addr   = valid_q ? base + pair_cnt : 2'd0;
   end

endmodule

// File: tb/tb_nrs_seq_gen.sv
// Bench for nrs_seq_gen: Gold-sequence reference model with per-cycle
// compare on a zero-skip instance and a default-parameter instance.
module tb_nrs_seq_gen;

   localparam int NP = 2;
   localparam int L0 = 0;
   localparam int L1 = 1600 + 218;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic [30:0] ci0, ci1;
   logic [1:0]  ab0, ab1;
   logic        busy0, valid0, r0, i0, done0;
   logic        busy1, valid1, r1, i1, done1;
   logic [1:0]  wa0, wa1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nrs_seq_gen #(
      .N_C(0), .M_OFFSET(0), .N_PAIRS(NP), .CNT_W(1)
   ) u0 (
      .clk(clk), .rst(rst), .start(start0), .c_init(ci0),
      .addr_base(ab0), .busy(busy0), .nrs_valid(valid0),
      .nrs_r(r0), .nrs_i(i0), .wr_addr(wa0), .done(done0)
   );

   nrs_seq_gen u1 (
      .clk(clk), .rst(rst), .start(start1), .c_init(ci1),
      .addr_base(ab1), .busy(busy1), .nrs_valid(valid1),
      .nrs_r(r1), .nrs_i(i1), .wr_addr(wa1), .done(done1)
   );

   // reference: c(n) straight from the x1/x2 recurrences
   function automatic bit gold(input logic [30:0] c, input int n);
      bit a [0:2100];
      bit b [0:2100];
      for (int k = 0; k < 31; k++) begin
         a[k] = (k == 0);
         b[k] = c[k];
      end
      for (int k = 0; k + 31 <= n; k++) begin
         a[k+31] = a[k+3] ^ a[k];
         b[k+31] = b[k+3] ^ b[k+2] ^ b[k+1] ^ b[k];
      end
      return a[n] ^ b[n];
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   int         cyc = 0;
   bit         act_m [2];
   int         ms [2];
   logic [1:0] mb [2];
   bit         er [2][4];
   bit         ei [2][4];

   int         fv [2];
   int         dn [2];
   int         capn [2];
   int         ndone [2];
   bit         cr [2][4];
   bit         cq [2][4];
   logic [1:0] ca [2][4];

   function automatic int lof(input int d);
      return (d == 0) ? L0 : L1;
   endfunction

   // request model: a start is taken on any edge that follows an idle cycle
   initial begin
      act_m = '{1'b0, 1'b0};
      forever begin
         @(posedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            bit st;
            logic [30:0] c;
            logic [1:0] b;
            bit idle;
            st = (d == 0) ? start0 : start1;
            c  = (d == 0) ? ci0 : ci1;
            b  = (d == 0) ? ab0 : ab1;
            idle = !act_m[d] || (cyc - 1 - ms[d]) > lof(d) + NP;
            if (!rst) begin
               act_m[d] = 1'b0;
            end else if (idle && st) begin
               act_m[d] = 1'b1;
               ms[d] = cyc;
               mb[d] = b;
               for (int p = 0; p < NP; p++) begin
                  er[d][p] = gold(c, lof(d) + 2 * p);
                  ei[d][p] = gold(c, lof(d) + 2 * p + 1);
               end
            end
         end
      end
   end

   initial begin
      fv = '{-1, -1};
      dn = '{-1, -1};
      capn = '{0, 0};
      ndone = '{0, 0};
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            logic [6:0] got;
            logic [6:0] want;
            int off;
            int p;
            got = (d == 0) ? {busy0, valid0, done0, r0, i0, wa0}
                           : {busy1, valid1, done1, r1, i1, wa1};
            want = '0;
            off = cyc - ms[d];
            if (act_m[d] && off <= lof(d) + NP) begin
               want[6] = 1'b1;
               if (off == lof(d) + NP) begin
                  want[4] = 1'b1;
               end else if (off >= lof(d)) begin
                  p = off - lof(d);
                  want[5] = 1'b1;
                  want[3] = er[d][p];
                  want[2] = ei[d][p];
                  want[1:0] = mb[d] + 2'(p);
               end
            end
            chk((d == 0) ? "dut0_cycle" : "dut1_cycle", 32'(got), 32'(want));
            if (got[5]) begin
               if (fv[d] < 0) fv[d] = cyc;
               if (capn[d] < 4) begin
                  cr[d][capn[d]] = got[3];
                  cq[d][capn[d]] = got[2];
                  ca[d][capn[d]] = got[1:0];
               end
               capn[d]++;
            end
            if (got[4]) begin
               if (dn[d] < 0) dn[d] = cyc;
               ndone[d]++;
            end
         end
      end
   end

   task automatic drive(input int d, input bit s, input logic [30:0] c,
                        input logic [1:0] b);
      if (d == 0) begin
         start0 = s; ci0 = c; ab0 = b;
      end else begin
         start1 = s; ci1 = c; ab1 = b;
      end
   endtask

   task automatic clr(input int d);
      fv[d] = -1;
      dn[d] = -1;
      capn[d] = 0;
   endtask

   task automatic run_req(input int d, input logic [30:0] c,
                          input logic [1:0] b, input bit pulses);
      int L;
      int t0;
      L = lof(d);
      clr(d);
      drive(d, 1'b1, c, b);
      @(posedge clk);
      #1;
      t0 = cyc;
      drive(d, 1'b0, ~c, ~b);
      for (int k = 1; k <= L + NP + 3; k++) begin
         @(posedge clk);
         #1;
         if (pulses && (k == 5 || k == 1000))
            drive(d, 1'b1, c ^ 31'h5A5A5A5, ~b);
         else
            drive(d, 1'b0, ~c, ~b);
      end
      chk("first_valid_latency", fv[d] - t0 + 1, L + 1);
      chk("done_latency", dn[d] - t0 + 1, L + NP + 1);
      chk("pair_count", capn[d], NP);
   endtask

   function automatic logic [3:0] pairs0();
      return {cr[0][0], cq[0][0], cr[0][1], cq[0][1]};
   endfunction

   initial begin
      int nd;
      logic [30:0] c;
      rst = 1'b0;
      drive(0, 1'b1, 31'h0, 2'd0);
      drive(1, 1'b1, 31'h1A2B3C4, 2'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {26'd0, busy0, busy1, valid0, valid1, done0, done1}, 0);
      chk("reset_data", {26'd0, r0, i0, r1, i1, wa1}, 0);
      drive(0, 1'b0, 31'h0, 2'd0);
      drive(1, 1'b0, 31'h0, 2'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      chk("gold_c0_0", 32'(gold(31'h0, 0)), 1);
      chk("gold_c0_1", 32'(gold(31'h0, 1)), 0);
      chk("gold_c0_31", 32'(gold(31'h0, 31)), 1);
      chk("gold_c0_32", 32'(gold(31'h0, 32)), 0);
      chk("gold_c2_1", 32'(gold(31'h2, 1)), 1);

      run_req(0, 31'h0, 2'd0, 1'b0);
      chk("cinit0_pairs", 32'(pairs0()), 32'b1000);
      chk("cinit0_addr", {28'd0, ca[0][0], ca[0][1]}, 32'b0001);
      run_req(0, 31'h1, 2'd0, 1'b0);
      chk("cinit1_pairs", 32'(pairs0()), 32'b0000);
      run_req(0, 31'h2, 2'd0, 1'b0);
      chk("cinit2_pairs", 32'(pairs0()), 32'b1100);
      run_req(0, 31'h2, 2'd3, 1'b0);
      chk("base3_addr", {28'd0, ca[0][0], ca[0][1]}, 32'b1100);

      // start held high: one idle cycle between back-to-back requests
      nd = ndone[0];
      drive(0, 1'b1, 31'h0, 2'd1);
      repeat (8) @(posedge clk);
      #1;
      drive(0, 1'b0, 31'h0, 2'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("held_start_dones", ndone[0] - nd, 2);

      run_req(1, 31'h1A2B3C4, 2'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         c = 31'($urandom());
         run_req(1, c, 2'd2, 1'b0);
      end
      run_req(1, 31'h0ACE123, 2'd1, 1'b1);

      // abort during SKIP
      clr(1);
      drive(1, 1'b1, 31'h1A2B3C4, 2'd2);
      @(posedge clk);
      #1;
      drive(1, 1'b0, 31'h0, 2'd0);
      repeat (899) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("abort_skip_busy", 32'(busy1), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_skip_none", {30'd0, fv[1] >= 0, dn[1] >= 0}, 0);

      // abort during the second pair
      clr(1);
      drive(1, 1'b1, 31'h1A2B3C4, 2'd2);
      @(posedge clk);
      #1;
      drive(1, 1'b0, 31'h0, 2'd0);
      for (int k = 0; k < L1 + 5; k++) begin
         @(posedge clk);
         #1;
         if (fv[1] >= 0) break;
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_emit_pairs", capn[1], 2);
      chk("abort_emit_nodone", 32'(dn[1] >= 0), 0);

      run_req(1, 31'h1A2B3C4, 2'd2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nrs_seq_gen.md
Name: nrs_seq_gen

Overview:
- Generates the NB-IoT NRS QPSK sign bits (nrs_r, nrs_i) for one OFDM symbol per request.
- Uses the 3GPP 36.211 length-31 Gold sequence c(n).
- Sits directly upstream of the complex-conjugate multiplier stage. It supplies nrs_r/nrs_i sign bits plus the matching 2-bit wr_addr, one pilot per cycle, aligned with the received pilot samples.
- A 1 bit means -1/sqrt(2) on that component (nrs_r = c(2m'), nrs_i = c(2m'+1)).

Parameters:
- N_C, 1600, Gold-sequence discard length (shifts before c(0)).
- M_OFFSET, 218, extra bits skipped before the first emitted pair (2*m'_start, with m'_start = 109 for NRB_max_DL = 110).
- N_PAIRS, 2, QPSK pairs emitted per request (pilots per OFDM symbol); range 1..4.
- CNT_W, 11, skip-counter width; must satisfy 2^CNT_W > N_C+M_OFFSET.

Ports:
- clk        input   1   single clock, rising edge.
- rst        input   1   synchronous active-low reset.
- start      input   1   request pulse; sampled only in IDLE.
- c_init     input   31  cinit for this symbol; sampled with start.
- addr_base  input   2   wr_addr of first pilot; sampled with start.
- busy       output  1   high while a request is in progress (SKIP/EMIT/DONE).
- nrs_valid  output  1   nrs_r/nrs_i/wr_addr valid this cycle.
- nrs_r      output  1   sign bit c(2k).
- nrs_i      output  1   sign bit c(2k+1).
- wr_addr    output  2   addr_base + pair index, modulo 4.
- done       output  1   one-cycle pulse after the last pair.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low, evaluated on the clk rising edge. While rst=0: state IDLE; all outputs 0; x1, x2 and counters 0.
- LFSRs: 31-bit x1 and x2, bit i = x(n+i).
  - Each shift moves bits down by one and writes a new bit30.
  - x1 feedback: x1[3]^x1[0].
  - x2 feedback: x2[3]^x2[2]^x2[1]^x2[0].
  - Output bit: c(n) = x1[0]^x2[0]. Lookahead bit: c(n+1) = x1[1]^x2[1].
- FSM IDLE -> SKIP -> EMIT -> DONE -> IDLE.
- IDLE: if start=1 at edge k:
  - x1 <= 31'h1 (x1(0)=1, other bits 0).
  - x2 <= c_init.
  - Latch addr_base; clear skip counter and pair counter.
  - Go to SKIP, or to EMIT directly if N_C+M_OFFSET = 0.
- SKIP: exactly N_C+M_OFFSET cycles, one LFSR shift per cycle. Leaves x1/x2 aligned on c(N_C+M_OFFSET... ) i.e. c(0) of the emitted window.
- EMIT: N_PAIRS consecutive cycles.
  - Combinationally drive nrs_r = x1[0]^x2[0] and nrs_i = x1[1]^x2[1].
  - wr_addr = latched base + pair counter (2-bit wrap, e.g. base 3 -> 3, 0).
  - nrs_valid = 1.
  - At each edge, shift both LFSRs by 2 and increment the pair counter.
  - After the last pair, go to DONE.
- DONE: one cycle with done=1, nrs_valid=0, busy=1. Next state IDLE.
- Latency:
  - start at edge k -> first nrs_valid in cycle k+1+N_C+M_OFFSET (1819 cycles with defaults).
  - done in cycle k+1+N_C+M_OFFSET+N_PAIRS.
  - A new start is accepted in the cycle after done (IDLE).
- busy = 1 in SKIP, EMIT and DONE; 0 in IDLE.
- start while busy=1 is ignored, with no queueing; c_init and addr_base changes during busy are ignored.
- start held high continuously: a new request is accepted on every IDLE cycle, i.e. back-to-back requests separated by one IDLE cycle.
- rst=0 mid-operation (any state): next cycle is IDLE with all outputs 0. No done pulse for the aborted request.
- Outputs when nrs_valid=0: nrs_r, nrs_i and wr_addr are driven 0.
- No backpressure: the consumer must accept a pair on every nrs_valid cycle.

Test Plan:
- Reset: rst=0 for 3 cycles with start=1 -> busy, nrs_valid, done, nrs_r, nrs_i, wr_addr all 0; no request accepted.
- N_C=0, M_OFFSET=0, N_PAIRS=2, c_init=0, addr_base=0:
  - Pairs (nrs_r,nrs_i) = (1,0) at wr_addr 0, then (0,0) at wr_addr 1.
  - First valid 1 cycle after start; done 1 cycle after the last pair.
- Same parameters, c_init=1 -> pairs (0,0), (0,0). c_init=2 -> pairs (1,1), (0,0). addr_base=3 -> wr_addr 3 then 0.
- Defaults, c_init=31'h1A2B3C4 (and 4 further random values), addr_base=2:
  - First nrs_valid exactly 1819 cycles after start; done at 1821.
  - Bits bit-exact against a 36.211 Gold-sequence model at c(218..221).
- Start while busy: pulse start with a different c_init at cycles 5 and 1000 of a request -> ignored; output matches the first request; busy never drops early.
- Abort: rst=0 during SKIP (cycle 900) and during EMIT (pair 1) -> IDLE next cycle, no valid/done. A fresh start afterwards reproduces the golden sequence.
